// File: rtl/imm_field_packer_if.sv
// Loader-side and memory-side handshake bundle for imm_field_packer.
// master = program/key loader plus memory model, slave = the packer.
interface imm_field_packer_if #(
  parameter int N  = 32,
  parameter int AW = 10
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_word;
  logic [N-1:0]  in_imm;
  logic [1:0]    in_sel;
  logic          in_last;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] err_addr;
  logic [AW:0]   count;

  modport master (
    output start, base_addr, in_valid, in_word, in_imm, in_sel, in_last, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_addr, count
  );

  modport slave (
    input  start, base_addr, in_valid, in_word, in_imm, in_sel, in_last, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_addr, count
  );
endinterface

// File: rtl/imm_field_packer.sv
// Packs an immediate into its instruction field and streams packed words
// into instruction memory through a single registered write port.
module imm_field_packer #(
  parameter int N  = 32,
  parameter int AW = 10
) (
  input logic            clk,
  input logic            rst,
  imm_field_packer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic          last_taken;
  logic          accept, drain, pack_err;
  logic [N-1:0]  pack_data;
  logic [AW-1:0] beat_addr;

  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.wr_en & bus.wr_ready;
  // A beat accepted while the previous word drains lands one address further on.
  assign beat_addr = drain ? AW'(bus.wr_addr + 1'b1) : bus.wr_addr;

  always_comb begin
    pack_data = bus.in_word;
    pack_err  = 1'b1;
    case (bus.in_sel)
      2'b00: begin
        pack_data = {bus.in_word[31:14], bus.in_imm[11:0], bus.in_word[1:0]};
        pack_err  = |bus.in_imm[31:12];
      end
      2'b01: begin
        pack_data = {bus.in_word[31:19], bus.in_imm[18:0]};
        pack_err  = |bus.in_imm[31:19];
      end
      2'b10: begin
        pack_data = {bus.in_word[31:29], bus.in_imm[28:0]};
        pack_err  = |bus.in_imm[31:29];
      end
      default: begin
        pack_data = bus.in_word;
        pack_err  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = RUN;
      RUN:     if (last_taken && drain) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state == RUN);
    bus.done     = (state == DONE);
    bus.in_ready = (state == RUN) && !last_taken && (!bus.wr_en || bus.wr_ready);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.err      <= 1'b0;
      bus.err_addr <= '0;
      bus.count    <= '0;
      last_taken   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= bus.base_addr;
      bus.err      <= 1'b0;
      bus.err_addr <= '0;
      bus.count    <= '0;
      last_taken   <= 1'b0;
    end else if (state == RUN) begin
      if (drain) begin
        bus.count   <= bus.count + 1'b1;
        bus.wr_addr <= bus.wr_addr + 1'b1;
      end
      if (accept) begin
        bus.wr_en   <= 1'b1;
        bus.wr_data <= pack_data;
        if (bus.in_last) last_taken <= 1'b1;
        // err_addr records only the first offending word of the image.
        if (pack_err && !bus.err) begin
          bus.err      <= 1'b1;
          bus.err_addr <= beat_addr;
        end
      end else if (drain) begin
        bus.wr_en <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_imm_field_packer.sv
// Directed-vector bench for imm_field_packer: packing, errors, backpressure,
// address wrap, start filtering and asynchronous abort.
module tb_imm_field_packer;
  localparam int N  = 32;
  localparam int AW = 10;

  logic clk, rst;
  imm_field_packer_if #(.N(N), .AW(AW)) bus ();
  imm_field_packer #(.N(N), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int nvec = 0, nmis = 0, ndone = 0;
  bit hang = 0;
  logic [AW-1:0] qa[$];
  logic [N-1:0]  qd[$];

  initial clk = 0;
  always #5 clk = ~clk;

  // Completed writes and done cycles, observed mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en && bus.wr_ready) begin
      qa.push_back(bus.wr_addr);
      qd.push_back(bus.wr_data);
    end
    if (bus.done) ndone++;
  end

  task automatic do_start(input logic [AW-1:0] b);
    @(posedge clk); #1;
    bus.start = 1; bus.base_addr = b;
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic send(input logic [N-1:0] w, input logic [N-1:0] imm, input logic [1:0] s, input bit l);
    int t;
    t = 0;
    bus.in_valid = 1; bus.in_word = w; bus.in_imm = imm; bus.in_sel = s; bus.in_last = l;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 50) begin hang = 1; bus.in_valid = 0; return; end
    end
    @(posedge clk); #1;
    bus.in_valid = 0; bus.in_last = 0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.done) begin
      @(negedge clk);
      t++;
      if (t > 50) begin hang = 1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 0;
    #2 rst = 1;
    #1;
    nvec++; if ({bus.wr_en, bus.busy, bus.done, bus.err, bus.in_ready} !== 5'b0) begin nmis++; $display("FAIL reset.flags got %b want 00000", {bus.wr_en, bus.busy, bus.done, bus.err, bus.in_ready}); end
    nvec++; if ({bus.wr_addr, bus.err_addr, bus.count} !== '0) begin nmis++; $display("FAIL reset.addr_cnt got %h/%h/%h want 0", bus.wr_addr, bus.err_addr, bus.count); end
    nvec++; if (bus.wr_data !== 32'h0) begin nmis++; $display("FAIL reset.wr_data got %h want 0", bus.wr_data); end
    repeat (2) @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    nvec++; if ({bus.busy, bus.in_ready} !== 2'b00) begin nmis++; $display("FAIL reset.idle got %b want 00", {bus.busy, bus.in_ready}); end
  endtask

  task automatic test_pack_basic();
    logic [AW-1:0] ea[3];
    logic [N-1:0]  ed[3];
    int nd0;
    ea = '{10'h010, 10'h011, 10'h012};
    ed = '{32'hE0002AF3, 32'hE007FFFF, 32'hFFFFFFFF};
    qa.delete(); qd.delete(); nd0 = ndone;
    bus.wr_ready = 1;
    do_start(10'h010);
    nvec++; if (bus.busy !== 1'b1) begin nmis++; $display("FAIL basic.busy got %b want 1", bus.busy); end
    send(32'hE0000003, 32'h00000ABC, 2'b00, 0);
    send(32'hE0000003, 32'h0007FFFF, 2'b01, 0);
    send(32'hE0000003, 32'h1FFFFFFF, 2'b10, 1);
    wait_done();
    repeat (3) @(posedge clk); #1;
    nvec++; if (qa.size() !== 3) begin nmis++; $display("FAIL basic.nwrites got %0d want 3", qa.size()); end
    for (int i = 0; i < 3; i++) if (i < qa.size()) begin
      nvec++; if (qa[i] !== ea[i]) begin nmis++; $display("FAIL basic.addr%0d got %h want %h", i, qa[i], ea[i]); end
      nvec++; if (qd[i] !== ed[i]) begin nmis++; $display("FAIL basic.data%0d got %h want %h", i, qd[i], ed[i]); end
    end
    nvec++; if (bus.count !== 11'd3) begin nmis++; $display("FAIL basic.count got %0d want 3", bus.count); end
    nvec++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL basic.err got %b want 0", bus.err); end
    nvec++; if (ndone - nd0 !== 1) begin nmis++; $display("FAIL basic.done_cycles got %0d want 1", ndone - nd0); end
    nvec++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL basic.idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_errors();
    qa.delete(); qd.delete();
    do_start(10'h020);
    send(32'hE0000003, 32'h00001000, 2'b00, 0);
    nvec++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL err.first got %b want 1", bus.err); end
    nvec++; if (bus.err_addr !== 10'h020) begin nmis++; $display("FAIL err.first_addr got %h want 020", bus.err_addr); end
    send(32'h12345678, 32'h00000000, 2'b11, 1);
    wait_done();
    @(posedge clk); #1;
    nvec++; if (qa.size() !== 2) begin nmis++; $display("FAIL err.nwrites got %0d want 2", qa.size()); end
    if (qa.size() == 2) begin
      nvec++; if (qd[0] !== 32'hE0000003) begin nmis++; $display("FAIL err.trunc_data got %h want E0000003", qd[0]); end
      nvec++; if (qd[1] !== 32'h12345678) begin nmis++; $display("FAIL err.sel11_data got %h want 12345678", qd[1]); end
      nvec++; if (qa[1] !== 10'h021) begin nmis++; $display("FAIL err.sel11_addr got %h want 021", qa[1]); end
    end
    nvec++; if (bus.err_addr !== 10'h020) begin nmis++; $display("FAIL err.addr_held got %h want 020", bus.err_addr); end
    nvec++; if (bus.err !== 1'b1) begin nmis++; $display("FAIL err.sticky got %b want 1", bus.err); end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] ed[3];
    ed = '{32'h00000004, 32'hFFF92345, 32'h00000ABC};
    qa.delete(); qd.delete();
    bus.wr_ready = 1;
    do_start(10'h100);
    send(32'h00000000, 32'h00000001, 2'b00, 0);
    send(32'hFFFFFFFF, 32'h00012345, 2'b01, 0);
    bus.wr_ready = 0;
    bus.in_valid = 1; bus.in_word = 32'h0; bus.in_imm = 32'hABC; bus.in_sel = 2'b10; bus.in_last = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      nvec++; if (bus.wr_en !== 1'b1) begin nmis++; $display("FAIL bp.wr_en c%0d got %b want 1", c, bus.wr_en); end
      nvec++; if (bus.wr_addr !== 10'h101) begin nmis++; $display("FAIL bp.wr_addr c%0d got %h want 101", c, bus.wr_addr); end
      nvec++; if (bus.wr_data !== 32'hFFF92345) begin nmis++; $display("FAIL bp.wr_data c%0d got %h want FFF92345", c, bus.wr_data); end
      nvec++; if (bus.in_ready !== 1'b0) begin nmis++; $display("FAIL bp.in_ready c%0d got %b want 0", c, bus.in_ready); end
    end
    @(posedge clk); #1;
    bus.wr_ready = 1;
    send(32'h0, 32'hABC, 2'b10, 1);
    wait_done();
    @(posedge clk); #1;
    nvec++; if (qa.size() !== 3) begin nmis++; $display("FAIL bp.nwrites got %0d want 3", qa.size()); end
    for (int i = 0; i < 3; i++) if (i < qa.size()) begin
      nvec++; if (qa[i] !== 10'(10'h100 + i)) begin nmis++; $display("FAIL bp.addr%0d got %h want %h", i, qa[i], 10'h100 + i); end
      nvec++; if (qd[i] !== ed[i]) begin nmis++; $display("FAIL bp.data%0d got %h want %h", i, qd[i], ed[i]); end
    end
    nvec++; if (bus.count !== 11'd3) begin nmis++; $display("FAIL bp.count got %0d want 3", bus.count); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] ea[4];
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    qa.delete(); qd.delete();
    do_start(10'h3FE);
    for (int i = 0; i < 4; i++) send(32'h0, 32'(i + 1), 2'b01, i == 3);
    wait_done();
    @(posedge clk); #1;
    nvec++; if (qa.size() !== 4) begin nmis++; $display("FAIL wrap.nwrites got %0d want 4", qa.size()); end
    for (int i = 0; i < 4; i++) if (i < qa.size()) begin
      nvec++; if (qa[i] !== ea[i]) begin nmis++; $display("FAIL wrap.addr%0d got %h want %h", i, qa[i], ea[i]); end
      nvec++; if (qd[i] !== 32'(i + 1)) begin nmis++; $display("FAIL wrap.data%0d got %h want %h", i, qd[i], i + 1); end
    end
    nvec++; if (bus.count !== 11'd4) begin nmis++; $display("FAIL wrap.count got %0d want 4", bus.count); end
    nvec++; if (bus.err !== 1'b0) begin nmis++; $display("FAIL wrap.err got %b want 0", bus.err); end
  endtask

  task automatic test_start_ignored();
    qa.delete(); qd.delete();
    do_start(10'h200);
    send(32'h0, 32'h0, 2'b11, 0);
    bus.start = 1; bus.base_addr = 10'h300;
    @(posedge clk); #1;
    bus.start = 0;
    send(32'hFFFFFFFF, 32'h5, 2'b00, 1);
    wait_done();
    bus.start = 1; bus.base_addr = 10'h300;
    @(posedge clk); #1;
    bus.start = 0;
    @(posedge clk); #1;
    nvec++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL start.done_ignored busy got %b want 0", bus.busy); end
    nvec++; if (qa.size() !== 2) begin nmis++; $display("FAIL start.nwrites got %0d want 2", qa.size()); end
    if (qa.size() == 2) begin
      nvec++; if (qa[1] !== 10'h201) begin nmis++; $display("FAIL start.run_ignored addr got %h want 201", qa[1]); end
      nvec++; if (qd[1] !== 32'hFFFFC017) begin nmis++; $display("FAIL start.data got %h want FFFFC017", qd[1]); end
    end
    nvec++; if ({bus.err, bus.count} !== {1'b1, 11'd2}) begin nmis++; $display("FAIL start.held got err=%b count=%0d want 1/2", bus.err, bus.count); end
    do_start(10'h050);
    nvec++; if ({bus.busy, bus.err, bus.err_addr, bus.count} !== {1'b1, 1'b0, 10'h0, 11'd0}) begin nmis++; $display("FAIL start.clear got busy=%b err=%b ea=%h cnt=%0d want 1/0/0/0", bus.busy, bus.err, bus.err_addr, bus.count); end
    nvec++; if (bus.wr_addr !== 10'h050) begin nmis++; $display("FAIL start.base got %h want 050", bus.wr_addr); end
    send(32'h0, 32'h7, 2'b01, 1);
    wait_done();
    @(posedge clk); #1;
    nvec++; if (qa.size() !== 3 || qa[qa.size()-1] !== 10'h050) begin nmis++; $display("FAIL start.new_addr got n=%0d want 3 writes ending at 050", qa.size()); end
    nvec++; if (bus.count !== 11'd1) begin nmis++; $display("FAIL start.new_count got %0d want 1", bus.count); end
  endtask

  task automatic test_abort();
    int nd0;
    qa.delete(); qd.delete(); nd0 = ndone;
    bus.wr_ready = 0;
    do_start(10'h080);
    send(32'h0, 32'h1, 2'b00, 1);
    nvec++; if (bus.wr_en !== 1'b1) begin nmis++; $display("FAIL abort.pending got %b want 1", bus.wr_en); end
    #2 rst = 1;
    #1;
    nvec++; if ({bus.wr_en, bus.busy, bus.done, bus.err, bus.in_ready} !== 5'b0) begin nmis++; $display("FAIL abort.flags got %b want 00000", {bus.wr_en, bus.busy, bus.done, bus.err, bus.in_ready}); end
    nvec++; if ({bus.wr_addr, bus.wr_data, bus.err_addr, bus.count} !== '0) begin nmis++; $display("FAIL abort.regs got %h/%h/%h/%h want 0", bus.wr_addr, bus.wr_data, bus.err_addr, bus.count); end
    @(posedge clk); #1;
    rst = 0;
    bus.wr_ready = 1;
    repeat (5) @(posedge clk); #1;
    nvec++; if (ndone !== nd0) begin nmis++; $display("FAIL abort.no_done got %0d want %0d", ndone, nd0); end
    nvec++; if (qa.size() !== 0) begin nmis++; $display("FAIL abort.no_write got %0d want 0", qa.size()); end
    nvec++; if (bus.busy !== 1'b0) begin nmis++; $display("FAIL abort.idle got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.start = 0; bus.base_addr = '0; bus.in_valid = 0; bus.in_word = '0;
    bus.in_imm = '0; bus.in_sel = 2'b00; bus.in_last = 0; bus.wr_ready = 0;
    test_reset();
    test_pack_basic();
    test_errors();
    test_backpressure();
    test_wrap();
    test_start_ignored();
    test_abort();
    nvec++; if (hang !== 1'b0) begin nmis++; $display("FAIL handshake_timeout got %b want 0", hang); end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
